// File: rtl/data_mem_lsu_if.sv
// Request/response bundle between a MEM-stage client and data_mem_lsu.
// A request transfers on a rising edge where req_valid && req_ready; rsp_valid is a one-cycle strobe with no backpressure.
interface data_mem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_lsu.sv
// Handshaked word-organised data memory with RISC-V byte/half/word loads and stores,
// programmable wait states and error responses for misaligned, out-of-range or illegal accesses.
module data_mem_lsu #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    data_mem_lsu_if.slave      bus,
    output logic [1:0]         fsm_state
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [3:0] WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        lat_we;
    logic [2:0]  lat_f3;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic [31:0] mem [DEPTH];

    assign fsm_state = state;

    // With zero wait states the access happens on the accept edge, so it must see the live request.
    logic        a_we;
    logic [2:0]  a_f3;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic        access_fire;

    always_comb begin
        if (WAIT_STATES == 0) begin
            a_we        = bus.req_we;
            a_f3        = bus.req_funct3;
            a_addr      = bus.req_addr;
            a_wdata     = bus.req_wdata;
            access_fire = (state == S_IDLE) && bus.req_valid;
        end else begin
            a_we        = lat_we;
            a_f3        = lat_f3;
            a_addr      = lat_addr;
            a_wdata     = lat_wdata;
            access_fire = (state == S_WAIT) && (cnt == 4'd0);
        end
    end

    logic [31:0]   offset;
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic          bad_f3;
    logic          misaligned;
    logic          out_of_range;
    logic          err;

    assign offset = a_addr - BASE_ADDR;
    assign idx    = offset[AW+1:2];
    assign lane   = offset[1:0];

    always_comb begin
        if (a_we) begin
            bad_f3 = !(a_f3 == 3'b000 || a_f3 == 3'b001 || a_f3 == 3'b010);
        end else begin
            bad_f3 = (a_f3 == 3'b011 || a_f3 == 3'b110 || a_f3 == 3'b111);
        end
        misaligned   = ((a_f3[1:0] == 2'b01) && lane[0]) ||
                       ((a_f3[1:0] == 2'b10) && (lane != 2'b00));
        out_of_range = (a_addr < BASE_ADDR) || (|offset[31:AW+2]);
        err          = bad_f3 || misaligned || out_of_range;
    end

    // Store lane steering: data is replicated so each enabled byte lane picks its own copy.
    logic [3:0]  be;
    logic [31:0] wd;

    always_comb begin
        be = 4'b0000;
        wd = a_wdata;
        case (a_f3[1:0])
            2'b00: begin
                be = 4'b0001 << lane;
                wd = {4{a_wdata[7:0]}};
            end
            2'b01: begin
                be = lane[1] ? 4'b1100 : 4'b0011;
                wd = {2{a_wdata[15:0]}};
            end
            2'b10: begin
                be = 4'b1111;
                wd = a_wdata;
            end
            default: begin
                be = 4'b0000;
                wd = a_wdata;
            end
        endcase
    end

    logic mem_we;
    assign mem_we = access_fire && a_we && !err && rst_n;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wd[8*i +: 8];
                end
            end
        end
    end

    logic [31:0] rd_word;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_data;

    always_comb begin
        rd_word = mem[idx];
        case (lane)
            2'b00:   rd_byte = rd_word[7:0];
            2'b01:   rd_byte = rd_word[15:8];
            2'b10:   rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
        case (a_f3)
            3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
            3'b010:  load_data = rd_word;
            3'b100:  load_data = {24'd0, rd_byte};
            3'b101:  load_data = {16'd0, rd_half};
            default: load_data = 32'd0;
        endcase
    end

    logic [31:0] rsp_data_next;
    assign rsp_data_next = (a_we || err) ? 32'd0 : load_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            cnt           <= 4'd0;
            lat_we        <= 1'b0;
            lat_f3        <= 3'd0;
            lat_addr      <= 32'd0;
            lat_wdata     <= 32'd0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= 32'd0;
            bus.rsp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        lat_we        <= bus.req_we;
                        lat_f3        <= bus.req_funct3;
                        lat_addr      <= bus.req_addr;
                        lat_wdata     <= bus.req_wdata;
                        bus.req_ready <= 1'b0;
                        if (WAIT_STATES == 0) begin
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_rdata <= rsp_data_next;
                            bus.rsp_err   <= err;
                            state         <= S_RESP;
                        end else begin
                            cnt   <= WS_LOAD;
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_rdata <= rsp_data_next;
                        bus.rsp_err   <= err;
                        state         <= S_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    bus.rsp_valid <= 1'b0;
                    bus.req_ready <= 1'b1;
                    state         <= S_IDLE;
                end
                default: begin
                    bus.rsp_valid <= 1'b0;
                    bus.req_ready <= 1'b1;
                    state         <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu: three instances with 0, 1 and 3 wait states share one
// clock and request bus; the 1-wait-state instance runs a vector table, the others cover latency and reset.
module tb_data_mem_lsu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mid_n = 1'b1;
  logic rst3_n;
  always #5 clk = ~clk;
  assign rst3_n = rst_n && mid_n;

  logic [2:0]  vld = 3'b000;
  logic        t_we = 1'b0;
  logic [2:0]  t_f3 = 3'd0;
  logic [31:0] t_addr = 32'd0;
  logic [31:0] t_wdata = 32'd0;
  int          sel = 0;

  data_mem_lsu_if b0();
  data_mem_lsu_if b1();
  data_mem_lsu_if b3();
  logic [1:0] st0, st1, st3;

  assign b0.req_valid = vld[0];
  assign b1.req_valid = vld[1];
  assign b3.req_valid = vld[2];
  assign b0.req_we = t_we;    assign b1.req_we = t_we;    assign b3.req_we = t_we;
  assign b0.req_funct3 = t_f3; assign b1.req_funct3 = t_f3; assign b3.req_funct3 = t_f3;
  assign b0.req_addr = t_addr; assign b1.req_addr = t_addr; assign b3.req_addr = t_addr;
  assign b0.req_wdata = t_wdata; assign b1.req_wdata = t_wdata; assign b3.req_wdata = t_wdata;

  data_mem_lsu #(.DEPTH(256), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0), .fsm_state(st0));
  data_mem_lsu #(.DEPTH(256), .WAIT_STATES(1), .BASE_ADDR(32'h0)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1), .fsm_state(st1));
  data_mem_lsu #(.DEPTH(256), .WAIT_STATES(3), .BASE_ADDR(32'h0)) dut3 (
    .clk(clk), .rst_n(rst3_n), .bus(b3), .fsm_state(st3));

  logic        m_ready, m_valid, m_err;
  logic [31:0] m_rdata;
  logic [1:0]  m_state;
  always_comb begin
    case (sel)
      0: begin m_ready = b0.req_ready; m_valid = b0.rsp_valid; m_err = b0.rsp_err; m_rdata = b0.rsp_rdata; m_state = st0; end
      1: begin m_ready = b1.req_ready; m_valid = b1.rsp_valid; m_err = b1.rsp_err; m_rdata = b1.rsp_rdata; m_state = st1; end
      default: begin m_ready = b3.req_ready; m_valid = b3.rsp_valid; m_err = b3.rsp_err; m_rdata = b3.rsp_rdata; m_state = st3; end
    endcase
  end

  int n_vec = 0;
  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One full transaction: returns response data, error, accept-to-response latency and
  // whether req_ready stayed low until the cycle after rsp_valid.
  task automatic do_req(input int which, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output logic hs_ok, output logic [31:0] held);
    int guard;
    sel = which;
    hs_ok = 1'b1;
    @(negedge clk);
    guard = 0;
    while (!m_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!m_ready) hs_ok = 1'b0;
    t_we = we; t_f3 = f3; t_addr = addr; t_wdata = wdata;
    vld[which] = 1'b1;
    @(negedge clk);
    vld[which] = 1'b0;
    t_wdata = 32'hA5A5_5A5A;
    t_addr = 32'h0000_0004;
    lat = 1;
    while (!m_valid && lat < 40) begin
      if (m_ready) hs_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (!m_valid) lat = -1;
    rdata = m_rdata;
    err = m_err;
    if (m_ready) hs_ok = 1'b0;
    @(negedge clk);
    if (!m_ready || m_valid) hs_ok = 1'b0;
    held = m_rdata;
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] er, input logic ee);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.exp_rdata = er; v.exp_err = ee;
    return v;
  endfunction

  logic [31:0] rdata, held;
  logic        err, hs_ok, quiet;
  int          lat;

  initial begin
    vt.push_back(mk(1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        0)); // SW
    vt.push_back(mk(0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 0)); // LW
    vt.push_back(mk(1, 3'b000, 32'h13,  32'h00000080, 32'h0,        0)); // SB
    vt.push_back(mk(0, 3'b000, 32'h13,  32'h0,        32'hFFFFFF80, 0)); // LB
    vt.push_back(mk(0, 3'b100, 32'h13,  32'h0,        32'h00000080, 0)); // LBU
    vt.push_back(mk(0, 3'b010, 32'h10,  32'h0,        32'h80ADBEEF, 0)); // LW
    vt.push_back(mk(1, 3'b001, 32'h12,  32'h00001234, 32'h0,        0)); // SH
    vt.push_back(mk(0, 3'b001, 32'h12,  32'h0,        32'h00001234, 0)); // LH
    vt.push_back(mk(0, 3'b001, 32'h11,  32'h0,        32'h0,        1)); // LH misaligned
    vt.push_back(mk(1, 3'b010, 32'h11,  32'hFFFFFFFF, 32'h0,        1)); // SW misaligned
    vt.push_back(mk(0, 3'b010, 32'h10,  32'h0,        32'h1234BEEF, 0)); // word intact
    vt.push_back(mk(0, 3'b010, 32'h400, 32'h0,        32'h0,        1)); // out of range
    vt.push_back(mk(0, 3'b011, 32'h10,  32'h0,        32'h0,        1)); // illegal load size
    vt.push_back(mk(1, 3'b100, 32'h10,  32'h0,        32'h0,        1)); // illegal store size
    vt.push_back(mk(0, 3'b010, 32'h10,  32'h0,        32'h1234BEEF, 0)); // no write happened
    vt.push_back(mk(0, 3'b101, 32'h10,  32'h0,        32'h0000BEEF, 0)); // LHU
    vt.push_back(mk(0, 3'b001, 32'h10,  32'h0,        32'hFFFFBEEF, 0)); // LH
    vt.push_back(mk(0, 3'b000, 32'h11,  32'h0,        32'hFFFFFFBE, 0)); // LB lane 1
    vt.push_back(mk(0, 3'b100, 32'h12,  32'h0,        32'h00000034, 0)); // LBU lane 2
    vt.push_back(mk(1, 3'b010, 32'h3FC, 32'hCAFEF00D, 32'h0,        0)); // last word
    vt.push_back(mk(0, 3'b010, 32'h3FC, 32'h0,        32'hCAFEF00D, 0));
    vt.push_back(mk(1, 3'b000, 32'h400, 32'h000000AA, 32'h0,        1)); // SB out of range
    vt.push_back(mk(0, 3'b110, 32'h10,  32'h0,        32'h0,        1)); // illegal load size
    vt.push_back(mk(0, 3'b010, 32'h3FC, 32'h0,        32'hCAFEF00D, 0));

    // Reset values
    repeat (3) @(negedge clk);
    sel = 1;
    #1;
    check("reset ready",  {31'd0, m_ready}, 32'd1);
    check("reset valid",  {31'd0, m_valid}, 32'd0);
    check("reset rdata",  m_rdata, 32'd0);
    check("reset err",    {31'd0, m_err}, 32'd0);
    check("reset state",  {30'd0, m_state}, 32'd0);
    n_vec++;
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors on the 1-wait-state instance
    for (int i = 0; i < vt.size(); i++) begin
      do_req(1, vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata, rdata, err, lat, hs_ok, held);
      n_vec++;
      check($sformatf("v%0d rdata", i), rdata, vt[i].exp_rdata);
      check($sformatf("v%0d err", i), {31'd0, err}, {31'd0, vt[i].exp_err});
      check($sformatf("v%0d latency", i), 32'(lat), 32'd2);
      check($sformatf("v%0d handshake", i), {31'd0, hs_ok}, 32'd1);
      check($sformatf("v%0d hold", i), held, vt[i].exp_rdata);
    end

    // Latency sweep: zero wait states
    do_req(0, 1, 3'b010, 32'h10, 32'hAABBCCDD, rdata, err, lat, hs_ok, held);
    n_vec++;
    check("ws0 sw latency", 32'(lat), 32'd1);
    check("ws0 sw handshake", {31'd0, hs_ok}, 32'd1);
    do_req(0, 0, 3'b010, 32'h10, 32'h0, rdata, err, lat, hs_ok, held);
    n_vec++;
    check("ws0 lw rdata", rdata, 32'hAABBCCDD);
    check("ws0 lw latency", 32'(lat), 32'd1);
    do_req(0, 0, 3'b100, 32'h11, 32'h0, rdata, err, lat, hs_ok, held);
    n_vec++;
    check("ws0 lbu rdata", rdata, 32'h000000CC);

    // Latency sweep: three wait states
    do_req(2, 1, 3'b010, 32'h20, 32'h55555555, rdata, err, lat, hs_ok, held);
    n_vec++;
    check("ws3 sw latency", 32'(lat), 32'd4);
    check("ws3 sw handshake", {31'd0, hs_ok}, 32'd1);
    do_req(2, 0, 3'b010, 32'h20, 32'h0, rdata, err, lat, hs_ok, held);
    n_vec++;
    check("ws3 lw rdata", rdata, 32'h55555555);
    check("ws3 lw latency", 32'(lat), 32'd4);

    // Reset in the second WAIT cycle drops the pending store
    sel = 2;
    @(negedge clk);
    t_we = 1'b1; t_f3 = 3'b010; t_addr = 32'h20; t_wdata = 32'h11111111;
    vld[2] = 1'b1;
    @(negedge clk);
    vld[2] = 1'b0;
    @(negedge clk);
    check("mid state wait", {30'd0, m_state}, 32'd1);
    mid_n = 1'b0;
    #1;
    n_vec++;
    check("mid reset ready", {31'd0, m_ready}, 32'd1);
    check("mid reset valid", {31'd0, m_valid}, 32'd0);
    check("mid reset rdata", m_rdata, 32'd0);
    check("mid reset state", {30'd0, m_state}, 32'd0);
    @(negedge clk);
    mid_n = 1'b1;
    quiet = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (m_valid) quiet = 1'b0;
    end
    check("mid no response", {31'd0, quiet}, 32'd1);
    do_req(2, 0, 3'b010, 32'h20, 32'h0, rdata, err, lat, hs_ok, held);
    n_vec++;
    check("mid lw prior data", rdata, 32'h55555555);
    check("mid lw err", {31'd0, err}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/data_mem_lsu.md
# data_mem_lsu

Parametrised, handshaked data memory with RISC-V sub-word access for the processor's MEM stage. Accepts one load/store request at a time over a valid/ready interface and performs byte/halfword/word stores with byte enables. Loads return sign- or zero-extended data. Requests complete after a configurable number of wait states, and misaligned, out-of-range or illegal-size requests are flagged with an error response.

## Interface
Parameters:
- DEPTH, 256, memory size in 32-bit words (power of two, ≥4)
- WAIT_STATES, 1, extra cycles between accept and memory access (0..15)
- BASE_ADDR, 32'h0000_0000, byte address of word 0

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 (load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store: 000 SB, 001 SH, 010 SW)
- req_addr  in  32  byte address
- req_wdata  in  32  store data (rs2), low bytes used for SB/SH
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  request faulted (valid only with rsp_valid)

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. If req_valid, the block latches we, funct3, addr and wdata.
  - WAIT_STATES>0: go to WAIT with counter=WAIT_STATES-1.
  - WAIT_STATES=0: perform the access on the same edge and go to RESP.
- WAIT: counter decrements each cycle. On the edge where counter==0, the block performs the access and goes to RESP.
- RESP: rsp_valid=1 for exactly one cycle. There is no backpressure. Next state is IDLE.
- Access edge:
  - The store is written to the array.
  - For loads, extracted data is registered into rsp_rdata.
  - rsp_err is registered.
- Word index = (addr - BASE_ADDR) >> 2. Lane = addr[1:0].
- Error conditions (any one sets rsp_err):
  - Illegal funct3: loads 011/110/111; stores anything other than 000/001/010.
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]≠0.
  - addr < BASE_ADDR, or word index ≥ DEPTH.
- On error: no array write, and rsp_rdata=0.
- Stores: SB writes byte lane addr[1:0] with wdata[7:0]. SH writes lanes {addr[1],0}+1:0 with wdata[15:0]. SW writes all four lanes. Unselected bytes are unchanged.
- Loads: byte/half selected by lane. LB/LH sign-extend to 32 bits, LBU/LHU zero-extend, LW returns the word.
- Array contents are not reset; simulation initial value is X. rsp_rdata for a store is 0.

## Timing
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
- Latency: if the accept edge is cycle 0, rsp_valid is high during cycle WAIT_STATES+1.
- Throughput: one request per WAIT_STATES+2 cycles. req_ready returns high the cycle after rsp_valid.
- req_* inputs are ignored outside IDLE. The latched copy is used for the access.
- Read-after-write: a store's write is complete when its rsp_valid is seen. A following load returns the new data.
- Reset asserted mid-operation (WAIT or RESP):
  - Return immediately to IDLE and clear outputs.
  - A store whose access edge has not yet occurred is dropped, leaving the array unchanged.
  - A store already written stays written.
- rsp_rdata and rsp_err hold their values after RESP until the next access edge.

## Test plan
- SW 32'hDEADBEEF to 0x10, then LW 0x10 → rsp_rdata=32'hDEADBEEF, rsp_err=0. With WAIT_STATES=1, rsp_valid occurs 2 cycles after each accept.
- SB 32'h00000080 to 0x13, then LB 0x13 → 32'hFFFFFF80, LBU 0x13 → 32'h00000080, LW 0x10 → 32'h80ADBEEF. Other bytes are preserved.
- SH 32'h00001234 to 0x12, then LH 0x12 → 32'h00001234. LH 0x11 → rsp_err=1, rdata=0. SW to 0x11 → rsp_err=1, and the word at 0x10 is unchanged.
- Out of range and illegal size, with DEPTH=256, BASE_ADDR=0:
  - LW 0x400 → rsp_err=1.
  - Load with funct3=011 → rsp_err=1.
  - Store with funct3=100 → rsp_err=1, no write.
- Latency sweep: with WAIT_STATES=0, rsp_valid appears 1 cycle after accept. With WAIT_STATES=3, it appears 4 cycles after accept. req_ready stays low until the cycle after rsp_valid.
- Reset mid-op: WAIT_STATES=3, SW 32'h11111111 to 0x20, rst_n pulsed low in the 2nd WAIT cycle → outputs reset immediately. A following LW 0x20 returns the prior contents, not 32'h11111111.
